// File: rtl/led_pkg.sv
// Shared encodings and cycle-length helper for the LED pattern engine and its pattern map.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_FILL_DRAIN = 2'd0,
    MODE_CHASE      = 2'd1,
    MODE_BOUNCE     = 2'd2,
    MODE_BLINK      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of pattern steps in one full cycle of the given mode.
  function automatic int unsigned cycle_len(input mode_e m, input int unsigned width);
    case (m)
      MODE_FILL_DRAIN: return 2 * width;
      MODE_CHASE:      return width;
      MODE_BOUNCE:     return 2 * width - 2;
      default:         return 2;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_map.sv
// Combinational (mode, dir, idx) -> LED pattern lookup; dir=1 bit-reverses the result.
module led_pattern_map
  import led_pkg::*;
#(
  parameter  int unsigned WIDTH = 18,
  localparam int unsigned IW    = $clog2(2 * WIDTH)
) (
  input  mode_e            i_mode,
  input  logic             i_dir,
  input  logic [IW-1:0]    i_idx,
  output logic [WIDTH-1:0] o_pattern
);

  int unsigned      w_idx;
  int unsigned      w_fill;
  int unsigned      w_pos;
  logic [WIDTH-1:0] w_fwd;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    w_fwd     = '0;
    o_pattern = '0;
    w_idx     = 32'(i_idx);
    // Fill count climbs to WIDTH ones, then drains down to zero ones on the last step.
    w_fill    = (w_idx < WIDTH) ? w_idx + 1 : 2 * WIDTH - 1 - w_idx;
    w_pos     = (w_idx < WIDTH) ? w_idx : 2 * WIDTH - 2 - w_idx;

    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (i_mode)
        MODE_FILL_DRAIN: w_fwd[i] = (i < w_fill);
        MODE_CHASE:      w_fwd[i] = (i == w_idx);
        MODE_BOUNCE:     w_fwd[i] = (i == w_pos);
        default:         w_fwd[i] = (w_idx == 0);
      endcase
    end

    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_pattern[i] = i_dir ? w_fwd[WIDTH-1-i] : w_fwd[i];
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED sequence engine: start/done level handshake, step-paced pattern index, repeat counter.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                async_rs_n,
  input  logic                start,
  input  logic                step_en,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic [REPEAT_W-1:0] repeats,
  output logic [WIDTH-1:0]    out,
  output logic                busy,
  output logic                done
);

  localparam int unsigned IW = $clog2(2 * WIDTH);

  state_e              r_state;
  logic [IW-1:0]       r_idx;
  logic [REPEAT_W-1:0] r_rep_cnt;
  mode_e               r_mode;
  logic                r_dir;
  logic [REPEAT_W-1:0] r_repeats;
  logic [WIDTH-1:0]    r_out;
  logic                r_busy;
  logic                r_done;

  state_e              w_next_state;
  logic [IW-1:0]       w_next_idx;
  logic [REPEAT_W-1:0] w_next_rep;
  logic                w_launch;
  mode_e               w_map_mode;
  logic                w_map_dir;
  logic [IW-1:0]       w_last_idx;
  logic [REPEAT_W-1:0] w_rep_inc;
  logic [WIDTH-1:0]    w_pattern;

  assign w_last_idx = IW'(cycle_len(r_mode, WIDTH) - 1);
  assign w_rep_inc  = r_rep_cnt + REPEAT_W'(1);

  // At launch the pattern must come from the live inputs, not the not-yet-latched copies.
  assign w_map_mode = w_launch ? mode_e'(mode) : r_mode;
  assign w_map_dir  = w_launch ? dir : r_dir;

  led_pattern_map #(.WIDTH(WIDTH)) u_map (
    .i_mode    (w_map_mode),
    .i_dir     (w_map_dir),
    .i_idx     (w_next_idx),
    .o_pattern (w_pattern)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_rep   = r_rep_cnt;
    w_launch     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_launch     = 1'b1;
          w_next_idx   = '0;
          w_next_rep   = '0;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!start) begin
          w_next_state = ST_IDLE;
          w_next_idx   = '0;
        end else if (step_en) begin
          if (r_idx == w_last_idx) begin
            w_next_idx = '0;
            if (r_repeats != '0) begin
              w_next_rep = w_rep_inc;
              if (w_rep_inc == r_repeats) w_next_state = ST_DONE;
            end
          end else begin
            w_next_idx = r_idx + IW'(1);
          end
        end
      end
      ST_DONE: begin
        if (!start) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge async_rs_n) begin
    if (!async_rs_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rep_cnt <= '0;
      r_mode    <= MODE_FILL_DRAIN;
      r_dir     <= 1'b0;
      r_repeats <= '0;
      r_out     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_idx     <= w_next_idx;
      r_rep_cnt <= w_next_rep;
      if (w_launch) begin
        r_mode    <= mode_e'(mode);
        r_dir     <= dir;
        r_repeats <= repeats;
      end
      // The LEDs show pattern(idx) only while running; IDLE and DONE force them dark.
      r_out  <= (w_next_state == ST_RUN) ? w_pattern : '0;
      r_busy <= (w_next_state == ST_RUN);
      r_done <= (w_next_state == ST_DONE);
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench: vector tables plus hand sequences on 4- and 18-LED engines, scoreboard queue.
module tb_led_pattern_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0;
  logic        start18 = 1'b0;
  logic        step_en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        dir = 1'b0;
  logic [3:0]  repeats = 4'd0;
  logic [3:0]  o4;
  logic        b4, d4;
  logic [17:0] o18;
  logic        b18, d18;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [17:0] out;
    logic        busy;
    logic        done;
    bit          wide;
    string       name;
  } exp_t;

  typedef struct {
    logic       s;
    logic       se;
    logic [1:0] m;
    logic       d;
    logic [3:0] r;
    logic [3:0] eo;
    logic       eb;
    logic       ed;
  } vec_t;

  exp_t scoreboard[$];
  vec_t vecs[$];

  logic [3:0] bounce_rev [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};

  always #5 clk = ~clk;

  led_pattern_engine #(.WIDTH(4), .REPEAT_W(4)) u_dut4 (
    .clk(clk), .async_rs_n(rst_n), .start(start4), .step_en(step_en),
    .mode(mode), .dir(dir), .repeats(repeats), .out(o4), .busy(b4), .done(d4)
  );

  led_pattern_engine #(.WIDTH(18), .REPEAT_W(4)) u_dut18 (
    .clk(clk), .async_rs_n(rst_n), .start(start18), .step_en(step_en),
    .mode(mode), .dir(dir), .repeats(repeats), .out(o18), .busy(b18), .done(d18)
  );

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got out/busy/done=%h required %h", nm, act, req);
    end
  endtask

  // Drive one clock of stimulus, queue its expectation, compare after the edge.
  task automatic cycle(input bit wide, input logic s, input logic se, input logic [1:0] m,
                       input logic d, input logic [3:0] r, input logic [17:0] eo,
                       input logic eb, input logic ed, input string nm);
    exp_t e;
    logic [19:0] act;
    start4  = wide ? 1'b0 : s;
    start18 = wide ? s : 1'b0;
    step_en = se;
    mode    = m;
    dir     = d;
    repeats = r;
    scoreboard.push_back('{out: eo, busy: eb, done: ed, wide: wide, name: nm});
    @(posedge clk);
    #1;
    e   = scoreboard.pop_front();
    act = e.wide ? {o18, b18, d18} : {14'd0, o4, b4, d4};
    check(e.name, act, {e.out, e.busy, e.done});
  endtask

  task automatic run_vecs(input string nm);
    foreach (vecs[i])
      cycle(1'b0, vecs[i].s, vecs[i].se, vecs[i].m, vecs[i].d, vecs[i].r,
            {14'd0, vecs[i].eo}, vecs[i].eb, vecs[i].ed, $sformatf("%s[%0d]", nm, i));
    vecs.delete();
  endtask

  initial begin
    int pos;
    logic se;

    #1;
    check("reset_w4", {14'd0, o4, b4, d4}, 20'd0);
    check("reset_w18", {o18, b18, d18}, 20'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd1, 18'd0, 1'b0, 1'b0, "idle_hold");

    // Fill/drain, one repeat, then held done and release.
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0001, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0011, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b1111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0011, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0001, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0000, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0000, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 1, 4'b0000, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0000, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 4'b0000, 0, 0});
    run_vecs("fill");

    // Reversed bounce, two repeats: done exactly on the 12th step.
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'd2, {14'd0, bounce_rev[0]}, 1'b1, 1'b0, "bounce_launch");
    for (int k = 1; k < 12; k++)
      cycle(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'd2, {14'd0, bounce_rev[k % 6]}, 1'b1, 1'b0,
            $sformatf("bounce_step%0d", k));
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'd2, 18'd0, 1'b0, 1'b1, "bounce_done");
    cycle(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'd2, 18'd0, 1'b0, 1'b0, "bounce_release");

    // 18-wide endless chase with a strobe every third clock, then abort.
    cycle(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'd0, 18'd1, 1'b1, 1'b0, "chase_launch");
    pos = 0;
    for (int k = 0; k < 60; k++) begin
      se = (k % 3 == 2);
      if (se) pos = (pos + 1) % 18;
      cycle(1'b1, 1'b1, se, 2'd1, 1'b0, 4'd0, 18'd1 << pos, 1'b1, 1'b0,
            $sformatf("chase_clk%0d", k));
    end
    cycle(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 18'd0, 1'b0, 1'b0, "chase_abort");

    // Abort on the same edge as a step at idx 5, then restart.
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0001, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0011, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b1111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0011, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 4'b0000, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0001, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 4'b0000, 0, 0});
    run_vecs("abort");

    // Asynchronous reset mid-clock during a run.
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 18'd1, 1'b1, 1'b0, "arst_launch");
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 18'd2, 1'b1, 1'b0, "arst_step");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_immediate", {14'd0, o4, b4, d4}, 20'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 18'd1, 1'b1, 1'b0, "arst_relaunch");
    cycle(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd0, 18'd0, 1'b0, 1'b0, "arst_idle");

    // Launch-time inputs are frozen during a run; then a three-repeat blink.
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0001, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b0011, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b0111, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b1111, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b0111, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b0011, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b0001, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b0000, 1, 0});
    vecs.push_back('{1, 1, 3, 1, 3, 4'b0000, 0, 1});
    vecs.push_back('{0, 1, 3, 0, 3, 4'b0000, 0, 0});
    vecs.push_back('{1, 1, 3, 0, 3, 4'b1111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0000, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b1111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0000, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b1111, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0000, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'b0000, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 4'b0000, 0, 0});
    run_vecs("frozen");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
